goc_stimulus_sequencer: RTL and testbench
=========================================

// Module: goc_stimulus_sequencer
// PURPOSE
//  Upstream stimulus driver for the golden/faulty QR circuit pair. Generates pseudo-random
//  matrix elements from LFSRs, packs them into the 111-bit testVector, runs the START /
//  READY / REQUEST_OUT / VALID_OUT handshake per test case, and forwards each result beat,
//  tagged with its test index, to the downstream comparator. Runs a campaign of N tests.
// PARAMETERS
//  N_IN_ELEM   16   input elements per test (one per cycle after START)
//  N_OUT_BEAT  32   result beats expected per test (VALID_OUT cycles)
//  TIMEOUT     4095 max cycles in any wait state before abort
// PORTS
//  clk          in   1    system clock
//  rst          in   1    synchronous, active-high reset
//  run          in   1    pulse: start campaign (ignored unless IDLE)
//  num_tests    in   16   tests in campaign; 0 = campaign ends immediately
//  seed         in   32   LFSR seed, sampled on run
//  reduced      in   1    value driven on testVector[108] for whole campaign, sampled on run
//  testVector   out  111  [47:0] A_R, [95:48] A_I, [107:96] SIGMA, [108] REDUCED, [109] START, [110] REQUEST_OUT
//  resultVector in   202  [199:0] result data, [200] VALID_OUT, [201] READY
//  res_valid    out  1    one result beat forwarded this cycle
//  res_data     out  200  copy of resultVector[199:0] on res_valid
//  res_index    out  16   test index (0-based) of forwarded beat
//  res_beat     out  5    beat number within test, 0..N_OUT_BEAT-1
//  busy         out  1    campaign in progress
//  done         out  1    one-cycle pulse at campaign end
//  timeout_err  out  1    sticky; set on abort, cleared on rst or next run
// BEHAVIOUR
//  Reset: all outputs 0, testVector 0, FSM IDLE, counters 0, LFSRs = 0.
//  LFSR: four 32-bit Galois LFSRs, poly x^32+x^22+x^2+x+1 (mask 0x80200003), seeded with
//   seed^0x00000000, ^0x5A5A5A5A, ^0xA5A5A5A5, ^0x3C3C3C3C; any lane seeding to 0 uses 0x1.
//   Concatenation {L3,L2,L1,L0}[107:0] is the element payload; all lanes step once per FEED cycle only.
//  FSM states:
//   IDLE      -> on run: latch seed/reduced, clear counters and timeout_err; busy=1;
//                num_tests==0 -> DONE, else WAIT_RDY.
//   WAIT_RDY  wait READY=1 -> FEED (next cycle). Timeout -> ABORT.
//   FEED      N_IN_ELEM cycles; payload driven on [107:0]; START=1 on first cycle only;
//                LFSRs advance after each cycle; then -> WAIT_VAL.
//   WAIT_VAL  REQUEST_OUT held 1; each VALID_OUT=1 cycle forwards one beat -> res_* next
//                cycle (1-cycle registered latency); after N_OUT_BEAT beats -> NEXT. Timeout -> ABORT.
//   NEXT      REQUEST_OUT=0; index++; index==num_tests -> DONE else WAIT_RDY.
//   ABORT     timeout_err=1 -> DONE (remaining tests skipped).
//   DONE      done=1 one cycle, busy=0 -> IDLE.
//  Timeout counter: clears on every state entry and on each VALID_OUT beat; abort when it
//   reaches TIMEOUT while still waiting.
//  testVector[108]=latched reduced while busy, 0 otherwise; [107:0]=0 outside FEED.
//  VALID_OUT outside WAIT_VAL ignored (no res_valid). VALID_OUT beyond N_OUT_BEAT: extra ignored.
//  run while busy ignored. rst mid-campaign: everything returns to reset values next cycle,
//   no done pulse.
//  res_beat width fixed 5 bits; N_OUT_BEAT <= 32 required. index wraps never (num_tests<=65535).
// TESTING
//  T1 seed=1, num_tests=1, READY=1, model returns 32 beats -> START exactly one cycle, 16 FEED
//     cycles with payload matching C LFSR model, res_index=0, res_beat 0..31, done pulse, busy=0.
//  T2 num_tests=3, READY delayed 10 cycles per test -> FEED starts 1 cycle after READY; res_index
//     0,1,2; test-2 payload continues LFSR sequence (no reseed).
//  T3 num_tests=0 -> busy 1 cycle, done pulse 2 cycles after run, no START.
//  T4 READY held 0 -> timeout_err=1 after 4095 wait cycles, done pulse, no res_valid.
//  T5 seed=0 -> lane0 starts at 0x1 (not stuck); 40 VALID_OUT beats -> only 32 forwarded.
//  T6 rst asserted during FEED of test 1 -> testVector=0, busy=0, no done; new run works normally.

Source files
------------

// File: rtl/goc_stimulus_sequencer.sv
// -----------------------------------------------------------------------------
// goc_stimulus_sequencer
//
// Upstream stimulus driver for the golden/faulty QR circuit pair. For each test
// of a campaign it waits for READY, streams N_IN_ELEM pseudo-random matrix
// elements (from four Galois LFSR lanes) on testVector, then raises
// REQUEST_OUT and forwards N_OUT_BEAT result beats, each tagged with its
// test index and beat number, to the downstream comparator.
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   run            start pulse, honoured only while idle
//   num_tests      number of tests in the campaign (0 = end immediately)
//   seed           LFSR seed, sampled on run
//   reduced        REDUCED flag for the whole campaign, sampled on run
//   testVector     [47:0] A_R, [95:48] A_I, [107:96] SIGMA, [108] REDUCED,
//                  [109] START, [110] REQUEST_OUT
//   resultVector   [199:0] result data, [200] VALID_OUT, [201] READY
//   res_valid      one result beat forwarded this cycle
//   res_data       result data of the forwarded beat
//   res_index      0-based test index of the forwarded beat
//   res_beat       beat number within the test
//   busy           campaign in progress
//   done           one-cycle pulse at campaign end
//   timeout_err    sticky abort flag, cleared by rst or the next run
//   dbg_state      current FSM state
//
// Handshake: READY is sampled only in WAIT_RDY; the first FEED cycle (START=1)
// follows the cycle in which READY was seen high. VALID_OUT is sampled only in
// WAIT_VAL while REQUEST_OUT=1; every such cycle is one beat, and it appears on
// res_* exactly one cycle later with res_valid=1 for that single cycle.
// -----------------------------------------------------------------------------
module goc_stimulus_sequencer #(
    parameter int N_IN_ELEM  = 16,
    parameter int N_OUT_BEAT = 32,
    parameter int TIMEOUT    = 4095
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic [15:0]  num_tests,
    input  logic [31:0]  seed,
    input  logic         reduced,
    output logic [110:0] testVector,
    input  logic [201:0] resultVector,
    output logic         res_valid,
    output logic [199:0] res_data,
    output logic [15:0]  res_index,
    output logic [4:0]   res_beat,
    output logic         busy,
    output logic         done,
    output logic         timeout_err,
    output logic [2:0]   dbg_state
);

    localparam int FCW = (N_IN_ELEM > 1) ? $clog2(N_IN_ELEM) : 1;
    localparam int TCW = $clog2(TIMEOUT + 1);
    localparam logic [31:0] LFSR_MASK = 32'h80200003;
    localparam logic [31:0] LANE_XOR [4] = '{32'h00000000, 32'h5A5A5A5A,
                                             32'hA5A5A5A5, 32'h3C3C3C3C};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_FEED     = 3'd2,
        S_WAIT_VAL = 3'd3,
        S_NEXT     = 3'd4,
        S_ABORT    = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t             state, state_next;
    logic [31:0]        lane [4];
    logic [FCW-1:0]     feed_cnt;
    logic [4:0]         beat_cnt;
    logic [15:0]        index;
    logic [15:0]        num_lat;
    logic               reduced_lat;
    logic [TCW-1:0]     tmo_cnt;

    logic ready, valid_out;
    logic last_feed, last_beat, last_test, tmo_hit;

    assign ready     = resultVector[201];
    assign valid_out = resultVector[200];
    assign last_feed = (feed_cnt == FCW'(N_IN_ELEM - 1));
    assign last_beat = (beat_cnt == 5'(N_OUT_BEAT - 1));
    assign last_test = ((index + 16'd1) == num_lat);
    // True in the TIMEOUT-th consecutive cycle spent in a wait state.
    assign tmo_hit   = (tmo_cnt == TCW'(TIMEOUT - 1));
    assign dbg_state = state;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_MASK : 32'h0);
    endfunction

    // An all-zero Galois LFSR never leaves zero, so such a lane starts at 1.
    function automatic logic [31:0] lane_seed(input logic [31:0] x);
        return (x == 32'h0) ? 32'h1 : x;
    endfunction

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (run) state_next = (num_tests == 16'd0) ? S_DONE : S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (ready)        state_next = S_FEED;
                else if (tmo_hit) state_next = S_ABORT;
            end
            S_FEED:     if (last_feed) state_next = S_WAIT_VAL;
            S_WAIT_VAL: begin
                if (valid_out) begin
                    if (last_beat) state_next = S_NEXT;
                end else if (tmo_hit) begin
                    state_next = S_ABORT;
                end
            end
            S_NEXT:     state_next = last_test ? S_DONE : S_WAIT_RDY;
            S_ABORT:    state_next = S_DONE;
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        testVector      = '0;
        testVector[108] = busy & reduced_lat;
        if (state == S_FEED) begin
            testVector[107:0] = {lane[3][11:0], lane[2], lane[1], lane[0]};
            testVector[109]   = (feed_cnt == '0);
        end
        testVector[110] = (state == S_WAIT_VAL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            for (int i = 0; i < 4; i++) lane[i] <= '0;
            feed_cnt    <= '0;
            beat_cnt    <= '0;
            index       <= '0;
            num_lat     <= '0;
            reduced_lat <= 1'b0;
            tmo_cnt     <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_index   <= '0;
            res_beat    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state     <= state_next;
            res_valid <= 1'b0;
            done      <= 1'b0;

            // Wait-state watchdog: restarts on any state change and on each beat.
            if (state_next != state)
                tmo_cnt <= '0;
            else if (state == S_WAIT_VAL && valid_out)
                tmo_cnt <= '0;
            else if (state == S_WAIT_RDY || state == S_WAIT_VAL)
                tmo_cnt <= tmo_cnt + TCW'(1);

            case (state)
                S_IDLE: begin
                    if (run) begin
                        for (int i = 0; i < 4; i++) lane[i] <= lane_seed(seed ^ LANE_XOR[i]);
                        num_lat     <= num_tests;
                        reduced_lat <= reduced;
                        feed_cnt    <= '0;
                        beat_cnt    <= '0;
                        index       <= '0;
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                S_FEED: begin
                    for (int i = 0; i < 4; i++) lane[i] <= lfsr_step(lane[i]);
                    feed_cnt <= last_feed ? '0 : feed_cnt + FCW'(1);
                end
                S_WAIT_VAL: begin
                    if (valid_out) begin
                        res_valid <= 1'b1;
                        res_data  <= resultVector[199:0];
                        res_index <= index;
                        res_beat  <= beat_cnt;
                        beat_cnt  <= last_beat ? '0 : beat_cnt + 5'(1);
                    end
                end
                S_NEXT:  index <= index + 16'd1;
                S_ABORT: timeout_err <= 1'b1;
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_goc_stimulus_sequencer.sv
module tb_goc_stimulus_sequencer;

    localparam int NB = 32;
    localparam int NE = 16;
    localparam logic [31:0] LANE_XOR [4] = '{32'h00000000, 32'h5A5A5A5A,
                                             32'hA5A5A5A5, 32'h3C3C3C3C};

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         run;
    logic [15:0]  num_tests;
    logic [31:0]  seed;
    logic         reduced;
    logic [110:0] testVector;
    logic [201:0] resultVector;
    logic         ready, valid_out;
    logic [199:0] rdata;
    logic         res_valid;
    logic [199:0] res_data;
    logic [15:0]  res_index;
    logic [4:0]   res_beat;
    logic         busy, done, timeout_err;
    logic [2:0]   dbg_state;

    assign resultVector = {ready, valid_out, rdata};

    always #5 clk = ~clk;

    goc_stimulus_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .num_tests(num_tests), .seed(seed),
        .reduced(reduced), .testVector(testVector), .resultVector(resultVector),
        .res_valid(res_valid), .res_data(res_data), .res_index(res_index),
        .res_beat(res_beat), .busy(busy), .done(done), .timeout_err(timeout_err),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [220:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int fwd_cnt, start_cnt, done_cnt;
    int cyc = 0;
    int run_cyc, done_cyc;
    logic [31:0] first_lane0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (testVector[109]) start_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (res_valid) begin
                fwd_cnt++;
                if (exp_q.size() == 0) check("unexpected_res_valid", res_valid, 1'b0);
                else check("result_beat", {res_index, res_beat, res_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model helpers ----------------
    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [199:0] rand200();
        logic [223:0] r;
        for (int k = 0; k < 7; k++) r[k*32 +: 32] = $urandom;
        return r[199:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_campaign(input int nt, input logic [31:0] sd, input logic rd,
                               input int rdly, input int nb, input int exp_fwd);
        logic [31:0]  m [4];
        logic [127:0] cat;
        logic [110:0] exp_tv;
        int waited;
        for (int i = 0; i < 4; i++) begin
            m[i] = sd ^ LANE_XOR[i];
            if (m[i] == 32'h0) m[i] = 32'h1;
        end
        fwd_cnt = 0; start_cnt = 0; done_cnt = 0;
        num_tests = 16'(nt); seed = sd; reduced = rd; run = 1'b1;
        run_cyc = cyc;
        @(negedge clk);
        run = 1'b0;
        check("busy_after_run", busy, 1'b1);
        check("timeout_err_after_run", timeout_err, 1'b0);
        for (int t = 0; t < nt; t++) begin
            for (int d = 0; d < rdly; d++) begin
                check("no_start_before_ready", testVector[109], 1'b0);
                @(negedge clk);
            end
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
            for (int e = 0; e < NE; e++) begin
                if (e > 0) @(negedge clk);
                cat    = {m[3], m[2], m[1], m[0]};
                exp_tv = {1'b0, (e == 0), rd, cat[107:0]};
                if (t == 0 && e == 0) first_lane0 = testVector[31:0];
                check("feed_vector", testVector, exp_tv);
                for (int i = 0; i < 4; i++) m[i] = lfsr_next(m[i]);
            end
            @(negedge clk);
            check("request_out", testVector[110], 1'b1);
            for (int b = 0; b < nb; b++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                valid_out = 1'b1;
                rdata     = rand200();
                if (b < NB) exp_q.push_back({16'(t), 5'(b), rdata});
                @(negedge clk);
                valid_out = 1'b0;
            end
            @(negedge clk);
        end
        waited = 0;
        while (done_cnt == 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("done_seen", done_cnt, 1);
        if (nt == 0) check("empty_done_latency", done_cyc - run_cyc, 2);
        check("busy_after_done", busy, 1'b0);
        check("idle_vector", testVector, '0);
        check("timeout_err_clear", timeout_err, 1'b0);
        check("beats_forwarded", fwd_cnt, exp_fwd);
        check("start_pulses", start_cnt, nt);
        check("scoreboard_drained", exp_q.size(), 0);
        @(negedge clk);
        check("done_single_pulse", done_cnt, 1);
    endtask

    typedef struct {
        int          nt;
        logic [31:0] sd;
        logic        rd;
        int          rdly;
        int          nb;
        int          exp_fwd;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int waited, nt;
        vecs[0] = '{1, 32'h00000001, 1'b0, 0, 32, 32};   // single test, READY at once
        vecs[1] = '{3, 32'hDEADBEEF, 1'b1, 10, 32, 96};  // READY delayed, LFSR continues
        vecs[2] = '{0, 32'h12345678, 1'b1, 0, 32, 0};    // empty campaign
        vecs[3] = '{1, 32'h00000000, 1'b0, 3, 40, 32};   // zero seed, surplus beats

        rst = 1'b1; run = 1'b0; num_tests = '0; seed = '0; reduced = 1'b0;
        ready = 1'b0; valid_out = 1'b0; rdata = '0;
        repeat (3) @(negedge clk);
        check("reset_vector", testVector, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_res_valid", res_valid, 1'b0);
        check("reset_timeout_err", timeout_err, 1'b0);
        check("reset_res_tag", {res_index, res_beat}, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            do_campaign(vecs[i].nt, vecs[i].sd, vecs[i].rd, vecs[i].rdly, vecs[i].nb, vecs[i].exp_fwd);
            if (vecs[i].sd == 32'h0) check("zero_seed_lane0", first_lane0, 32'h1);
        end

        // READY never arrives: abort after the wait-state timeout.
        fwd_cnt = 0; start_cnt = 0; done_cnt = 0;
        num_tests = 16'd2; seed = $urandom; reduced = 1'b1; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        waited = 1;
        while (!timeout_err && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        check("timeout_latency_window", (waited >= 4096 && waited <= 4098), 1'b1);
        waited = 0;
        while (done_cnt == 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("abort_done", done_cnt, 1);
        check("abort_busy", busy, 1'b0);
        check("abort_timeout_sticky", timeout_err, 1'b1);
        check("abort_no_beats", fwd_cnt, 0);
        check("abort_no_start", start_cnt, 0);
        repeat (3) @(negedge clk);
        check("abort_timeout_held", timeout_err, 1'b1);

        // Next run clears the sticky flag and works normally.
        do_campaign(1, 32'h0BADF00D, 1'b1, 2, 33, 32);

        // Reset in the middle of FEED.
        done_cnt = 0;
        num_tests = 16'd2; seed = 32'hCAFEF00D; reduced = 1'b1; run = 1'b1;
        @(negedge clk);
        run = 1'b0; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("rst_case_start", testVector[109], 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_vector", testVector, '0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_res_valid", res_valid, 1'b0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_mid_no_done", done_cnt, 0);
        check("rst_mid_idle_vector", testVector, '0);
        do_campaign(2, 32'h00000001, 1'b0, 1, 32, 64);

        // Random campaigns.
        for (int r = 0; r < 3; r++) begin
            nt = $urandom_range(1, 3);
            do_campaign(nt, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                        $urandom_range(32, 35), nt * NB);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
